// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants for the ID stage: opcodes, ALU op codes and the
// bit positions of the decode bundle, which EX reuses to unpack dcr.
package id_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011
  } alu_op_e;

  localparam int unsigned DCR_W         = 24;
  localparam int unsigned DCR_ILLEGAL   = 23;
  localparam int unsigned DCR_AUIPC     = 22;
  localparam int unsigned DCR_F3_LO     = 19;
  localparam int unsigned DCR_R         = 18;
  localparam int unsigned DCR_I_CS      = 17;
  localparam int unsigned DCR_I_LOAD    = 16;
  localparam int unsigned DCR_JALR      = 15;
  localparam int unsigned DCR_S         = 14;
  localparam int unsigned DCR_U         = 13;
  localparam int unsigned DCR_B         = 12;
  localparam int unsigned DCR_JAL       = 11;
  localparam int unsigned DCR_MDU       = 10;
  localparam int unsigned DCR_MDU_OP_LO = 7;
  localparam int unsigned DCR_SFT       = 6;
  localparam int unsigned DCR_ALU_LO    = 3;
  localparam int unsigned DCR_SFT_OP_LO = 1;
  localparam int unsigned DCR_USES_RS2  = 0;

endpackage

// File: rtl/id_stage_fwd_fwd_select.sv
// Per-operand bypass selector: youngest matching producer slot wins; a match
// whose data is not yet available raises stall when the operand is used.
module fwd_select #(
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned XLEN      = 32
) (
  input  logic [4:0]              rs,
  input  logic                    used,
  input  logic [XLEN-1:0]         rf_rdata,
  input  logic [FWD_DEPTH-1:0]    fwd_valid,
  input  logic [5*FWD_DEPTH-1:0]  fwd_rd,
  input  logic [FWD_DEPTH-1:0]    fwd_avail,
  input  logic [XLEN*FWD_DEPTH-1:0] fwd_data,
  output logic [XLEN-1:0]         value,
  output logic                    stall
);

  logic hit;

  always_comb begin
    hit   = 1'b0;
    stall = 1'b0;
    value = (rs == 5'd0) ? '0 : rf_rdata;
    for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
      if (!hit && fwd_valid[i] && fwd_rd[5*i +: 5] == rs && rs != 5'd0) begin
        hit = 1'b1;
        if (fwd_avail[i]) value = fwd_data[XLEN*i +: XLEN];
        else              stall = used;
      end
    end
  end

endmodule

// File: rtl/id_stage_fwd.sv
// RV32I(+M) decode stage: decodes, resolves operands through an N-deep bypass,
// stalls on unavailable producers and registers the result toward EX.
module id_stage_fwd
  import id_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned M_EXT     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               inst,
  input  logic [XLEN-1:0]           pc_in,
  output logic [4:0]                rf_raddr1,
  output logic [4:0]                rf_raddr2,
  input  logic [XLEN-1:0]           rf_rdata1,
  input  logic [XLEN-1:0]           rf_rdata2,
  input  logic [FWD_DEPTH-1:0]      fwd_valid,
  input  logic [5*FWD_DEPTH-1:0]    fwd_rd,
  input  logic [FWD_DEPTH-1:0]      fwd_avail,
  input  logic [XLEN*FWD_DEPTH-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           pc_out,
  output logic [XLEN-1:0]           rr1,
  output logic [XLEN-1:0]           rr2,
  output logic [4:0]                rd_out,
  output logic [XLEN-1:0]           imm_out,
  output logic [XLEN-1:0]           target_pc,
  output logic [DCR_W-1:0]          dcr
);

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic is_r, is_i_cs, is_load, is_jalr, is_s, is_u, is_auipc, is_b, is_jal;
  logic known, mdu, illegal, sft, uses_rs1, uses_rs2, writes;
  logic stall1, stall2, hazard, accept;
  logic [2:0]       alu_op;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_d, op1, op2, target_d;
  logic [DCR_W-1:0] dcr_d;

  logic            out_valid_q;
  logic [XLEN-1:0] pc_q, rr1_q, rr2_q, imm_q, target_q;
  logic [4:0]      rd_q;
  logic [DCR_W-1:0] dcr_q;

  assign opcode    = inst[6:0];
  assign f3        = inst[14:12];
  assign f7        = inst[31:25];
  assign rf_raddr1 = inst[19:15];
  assign rf_raddr2 = inst[24:20];

  assign is_r     = (opcode == OP);
  assign is_i_cs  = (opcode == OP_IMM);
  assign is_load  = (opcode == LOAD);
  assign is_jalr  = (opcode == JALR);
  assign is_s     = (opcode == STORE);
  assign is_auipc = (opcode == AUIPC);
  assign is_u     = (opcode == LUI) | is_auipc;
  assign is_b     = (opcode == BRANCH);
  assign is_jal   = (opcode == JAL);
  assign known    = is_r | is_i_cs | is_load | is_jalr | is_s | is_u | is_b | is_jal;

  assign mdu      = is_r & (f7 == 7'b0000001);
  assign illegal  = ~known | ((M_EXT == 0) & mdu & (f3 != 3'b000));
  assign sft      = (is_r | is_i_cs) & (f3[1:0] == 2'b01);
  assign uses_rs1 = is_r | is_i_cs | is_load | is_jalr | is_s | is_b;
  assign uses_rs2 = is_r | is_s | is_b;
  assign writes   = (is_r | is_i_cs | is_load | is_jalr | is_u | is_jal) & ~illegal;

  always_comb begin
    imm32 = '0;
    if (is_i_cs | is_load | is_jalr) imm32 = {{20{inst[31]}}, inst[31:20]};
    else if (is_s)   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    else if (is_b)   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (is_u)   imm32 = {inst[31:12], 12'b0};
    else if (is_jal) imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  end
  assign imm_d = XLEN'(signed'(imm32));

  always_comb begin
    alu_op = ALU_ADD;
    if (is_r)         alu_op = f3 | {2'b00, f7[5]};
    else if (is_i_cs) alu_op = f3;
    else if (is_b)    alu_op = {1'b0, f3[2], ~(f3[2] ^ f3[1])};
  end

  fwd_select #(.FWD_DEPTH(FWD_DEPTH), .XLEN(XLEN)) u_fwd1 (
    .rs(rf_raddr1), .used(uses_rs1), .rf_rdata(rf_rdata1),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_avail(fwd_avail), .fwd_data(fwd_data),
    .value(op1), .stall(stall1)
  );

  fwd_select #(.FWD_DEPTH(FWD_DEPTH), .XLEN(XLEN)) u_fwd2 (
    .rs(rf_raddr2), .used(uses_rs2), .rf_rdata(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_avail(fwd_avail), .fwd_data(fwd_data),
    .value(op2), .stall(stall2)
  );

  assign hazard   = in_valid & (stall1 | stall2);
  assign in_ready = rst & ~flush & ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // jalr bases on the bypassed rs1, so its target tracks forwarded data
  assign target_d = ((is_jalr ? op1 : pc_in) + imm_d) & ~XLEN'(3);

  assign dcr_d = {illegal, is_auipc, f3,
                  is_r, is_i_cs, is_load, is_jalr, is_s, is_u, is_b, is_jal, mdu,
                  f3, sft, alu_op, f3[2], f7[5], uses_rs2};

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      rr1_q       <= '0;
      rr2_q       <= '0;
      imm_q       <= '0;
      target_q    <= '0;
      rd_q        <= '0;
      dcr_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      pc_q        <= pc_in;
      rr1_q       <= op1;
      rr2_q       <= op2;
      imm_q       <= imm_d;
      target_q    <= target_d;
      rd_q        <= writes ? inst[11:7] : 5'd0;
      dcr_q       <= dcr_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = pc_q;
  assign rr1       = rr1_q;
  assign rr2       = rr2_q;
  assign imm_out   = imm_q;
  assign target_pc = target_q;
  assign rd_out    = rd_q;
  assign dcr       = dcr_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Bench for id_stage_fwd: directed vector table, multi-cycle handshake cases
// and randomized traffic against an ISA-level reference model.
module tb_id_stage_fwd;

  localparam int XLEN = 32;
  localparam int FD   = 3;

  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready;
  logic [31:0] inst, pc_in, rf_rdata1, rf_rdata2;
  logic [FD-1:0] fv, fav;
  logic [4:0]  frd [FD];
  logic [31:0] fdat [FD];
  logic [5*FD-1:0]    fwd_rd_bus;
  logic [XLEN*FD-1:0] fwd_data_bus;

  logic in_ready, out_valid;
  logic [4:0] rf_raddr1, rf_raddr2, rd_out;
  logic [31:0] pc_out, rr1, rr2, imm_out, target_pc;
  logic [23:0] dcr;

  logic in_ready0, out_valid0;
  logic [4:0] rf_raddr1_0, rf_raddr2_0, rd_out0;
  logic [31:0] pc_out0, rr1_0, rr2_0, imm_out0, target_pc0;
  logic [23:0] dcr0;

  assign fwd_rd_bus   = {frd[2], frd[1], frd[0]};
  assign fwd_data_bus = {fdat[2], fdat[1], fdat[0]};

  always #5 clk = ~clk;

  id_stage_fwd #(.XLEN(XLEN), .FWD_DEPTH(FD), .M_EXT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc_in(pc_in),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fv), .fwd_rd(fwd_rd_bus), .fwd_avail(fav), .fwd_data(fwd_data_bus), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .rr1(rr1), .rr2(rr2),
    .rd_out(rd_out), .imm_out(imm_out), .target_pc(target_pc), .dcr(dcr)
  );

  id_stage_fwd #(.XLEN(XLEN), .FWD_DEPTH(FD), .M_EXT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .inst(inst), .pc_in(pc_in),
    .rf_raddr1(rf_raddr1_0), .rf_raddr2(rf_raddr2_0), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fv), .fwd_rd(fwd_rd_bus), .fwd_avail(fav), .fwd_data(fwd_data_bus), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .pc_out(pc_out0), .rr1(rr1_0), .rr2(rr2_0),
    .rd_out(rd_out0), .imm_out(imm_out0), .target_pc(target_pc0), .dcr(dcr0)
  );

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0] rr1, rr2, imm, tgt;
    logic [4:0]  rd;
    logic [23:0] dcr;
    logic        stall;
  } exp_t;

  // An operand comes from the youngest producer naming it, else the regfile; x0 is 0.
  function automatic void resolve(input logic [4:0] rs, input logic [31:0] rf,
                                  output logic [31:0] v, output bit pend);
    v = (rs == 5'd0) ? 32'd0 : rf;
    pend = 1'b0;
    if (rs != 5'd0)
      for (int i = 0; i < FD; i++)
        if (fv[i] && frd[i] == rs) begin
          if (fav[i]) v = fdat[i];
          else pend = 1'b1;
          break;
        end
  endfunction

  function automatic exp_t model(input bit mext);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3, alu;
    bit r, ics, ld, jr, s, u, b, j, aui, known, mdu, ill, sft, use1, use2, p1, p2;
    int imm;
    opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    {r, ics, ld, jr, s, u, b, j, aui} = '0;
    known = 1'b1;
    case (opc)
      7'h33: r = 1'b1;
      7'h13: ics = 1'b1;
      7'h03: ld = 1'b1;
      7'h67: jr = 1'b1;
      7'h23: s = 1'b1;
      7'h37: u = 1'b1;
      7'h17: begin u = 1'b1; aui = 1'b1; end
      7'h63: b = 1'b1;
      7'h6F: j = 1'b1;
      default: known = 1'b0;
    endcase
    imm = 0;
    if (ics || ld || jr) imm = $signed(inst[31:20]);
    else if (s) imm = $signed({inst[31:25], inst[11:7]});
    else if (b) imm = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    else if (u) imm = {inst[31:12], 12'h000};
    else if (j) imm = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
    resolve(inst[19:15], rf_rdata1, e.rr1, p1);
    resolve(inst[24:20], rf_rdata2, e.rr2, p2);
    use1 = r || ics || ld || jr || s || b;
    use2 = r || s || b;
    if (r) alu = {f3[2:1], f3[0] | f7[5]};
    else if (ics) alu = f3;
    else if (b) alu = {1'b0, f3[2], ~(f3[2] ^ f3[1])};
    else alu = 3'd0;
    mdu = r && (f7 == 7'd1);
    ill = !known || (!mext && mdu && f3 != 3'd0);
    sft = (r || ics) && (f3[1:0] == 2'b01);
    e.imm = imm;
    e.rd  = ((r || ics || ld || jr || u || j) && !ill) ? inst[11:7] : 5'd0;
    e.dcr = {ill, aui, f3, r, ics, ld, jr, s, u, b, j, mdu, f3, sft, alu, f3[2], f7[5], use2};
    e.tgt = ((jr ? e.rr1 : pc_in) + e.imm) & 32'hFFFF_FFFC;
    e.stall = in_valid && ((use1 && p1) || (use2 && p2));
    return e;
  endfunction

  typedef struct {
    logic [31:0] inst, pc, rf1, rf2;
    logic [2:0]  fv, fav;
    logic [14:0] frd;
    logic [95:0] fd;
    logic [31:0] rr1, rr2, imm, tgt;
    logic [4:0]  rd;
    logic [2:0]  alu;
    logic [8:0]  ty;
  } vec_t;

  task automatic set_fwd(input logic [2:0] v, input logic [2:0] a,
                         input logic [14:0] r, input logic [95:0] d);
    fv = v; fav = a;
    for (int i = 0; i < FD; i++) begin
      frd[i]  = r[5*i +: 5];
      fdat[i] = d[32*i +: 32];
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_fwd(3'b000, 3'b111, '0, '0);
  endtask

  vec_t vecs [8];
  exp_t e, m_out;
  logic [31:0] m_pc;
  bit m_ov, exp_ir;
  logic [31:0] w;
  logic [6:0] opcs [10];

  initial begin
    vecs[0] = '{32'hFFD08293, 32'h200, 32'd10, 32'h55, 3'b000, 3'b111, 15'd0, 96'd0,
                32'd10, 32'h55, 32'hFFFFFFFD, 32'h1FC, 5'd5, 3'b000, 9'b010000000};
    vecs[1] = '{32'h002081B3, 32'h300, 32'd10, 32'd20, 3'b101, 3'b111, {5'd1, 5'd0, 5'd1},
                {32'd99, 32'd0, 32'd7}, 32'd7, 32'd20, 32'd0, 32'h300, 5'd3, 3'b000, 9'b100000000};
    vecs[2] = '{32'h002081B3, 32'h300, 32'd10, 32'd20, 3'b100, 3'b111, {5'd1, 5'd0, 5'd1},
                {32'd99, 32'd0, 32'd7}, 32'd99, 32'd20, 32'd0, 32'h300, 5'd3, 3'b000, 9'b100000000};
    vecs[3] = '{32'h002081B3, 32'h300, 32'd10, 32'd20, 3'b000, 3'b111, {5'd1, 5'd0, 5'd1},
                {32'd99, 32'd0, 32'd7}, 32'd10, 32'd20, 32'd0, 32'h300, 5'd3, 3'b000, 9'b100000000};
    vecs[4] = '{32'h00C300E7, 32'h500, 32'h1003, 32'h77, 3'b000, 3'b111, 15'd0, 96'd0,
                32'h1003, 32'h77, 32'hC, 32'h100C, 5'd1, 3'b000, 9'b000100000};
    vecs[5] = '{32'hFE208CE3, 32'h100, 32'd5, 32'd6, 3'b000, 3'b111, 15'd0, 96'd0,
                32'd5, 32'd6, 32'hFFFFFFF8, 32'hF8, 5'd0, 3'b001, 9'b000000100};
    vecs[6] = '{32'h123453B7, 32'h400, 32'h11, 32'h22, 3'b000, 3'b111, 15'd0, 96'd0,
                32'h11, 32'h22, 32'h12345000, 32'h12345400, 5'd7, 3'b000, 9'b000001000};
    vecs[7] = '{32'h0020A223, 32'h10, 32'h1000, 32'hAB, 3'b010, 3'b010, {5'd0, 5'd2, 5'd0},
                {32'd0, 32'hCD, 32'd0}, 32'h1000, 32'hCD, 32'd4, 32'h14, 5'd0, 3'b000, 9'b000010000};
    opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h7F};

    // reset, including with out_valid previously high
    idle();
    rst = 1'b0; in_valid = 1'b1; inst = 32'h002081B3; pc_in = 32'h40;
    rf_rdata1 = 32'd10; rf_rdata2 = 32'd20;
    #1 chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    tick(); tick();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("pre_reset_accept", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1 chk("in_ready_during_reset", 32'(in_ready), 32'd0);
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_dcr", 32'(dcr), 32'd0);
    chk("rst_rr1", rr1, 32'd0);
    chk("rst_imm", imm_out, 32'd0);
    chk("rst_target", target_pc, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    tick();

    // directed vector table
    foreach (vecs[k]) begin
      inst = vecs[k].inst; pc_in = vecs[k].pc; rf_rdata1 = vecs[k].rf1; rf_rdata2 = vecs[k].rf2;
      set_fwd(vecs[k].fv, vecs[k].fav, vecs[k].frd, vecs[k].fd);
      in_valid = 1'b1; out_ready = 1'b1;
      #1 e = model(1'b1);
      chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_rr1", k), rr1, vecs[k].rr1);
      chk($sformatf("v%0d_rr2", k), rr2, vecs[k].rr2);
      chk($sformatf("v%0d_imm", k), imm_out, vecs[k].imm);
      chk($sformatf("v%0d_target", k), target_pc, vecs[k].tgt);
      chk($sformatf("v%0d_rd", k), 32'(rd_out), 32'(vecs[k].rd));
      chk($sformatf("v%0d_alu_op", k), 32'(dcr[5:3]), 32'(vecs[k].alu));
      chk($sformatf("v%0d_type", k), 32'(dcr[18:10]), 32'(vecs[k].ty));
      chk($sformatf("v%0d_dcr_model", k), 32'(dcr), 32'(e.dcr));
      chk($sformatf("v%0d_pc_out", k), pc_out, vecs[k].pc);
    end
    idle();
    tick();

    // load-use stall, released the cycle the producer's data arrives
    inst = 32'h123453B7; in_valid = 1'b1;
    tick();
    inst = 32'h002081B3; rf_rdata1 = 32'd10; rf_rdata2 = 32'd20;
    set_fwd(3'b001, 3'b000, {5'd0, 5'd0, 5'd2}, {32'd0, 32'd0, 32'h1234});
    #1 chk("lu_in_ready_stalled", 32'(in_ready), 32'd0);
    tick();
    chk("lu_drained", 32'(out_valid), 32'd0);
    chk("lu_still_stalled", 32'(in_ready), 32'd0);
    tick();
    chk("lu_no_issue", 32'(out_valid), 32'd0);
    fav = 3'b001;
    #1 chk("lu_same_cycle_ready", 32'(in_ready), 32'd1);
    tick();
    chk("lu_out_valid", 32'(out_valid), 32'd1);
    chk("lu_rr2_fwd", rr2, 32'h1234);
    // pending producer on a field the instruction does not use
    inst = 32'h123453B7; fav = 3'b000; frd[0] = 5'd3;
    #1 chk("lui_no_hazard", 32'(in_ready), 32'd1);
    inst = 32'h002081B3; frd[0] = 5'd2; in_valid = 1'b0;
    #1 chk("no_hazard_when_idle", 32'(in_ready), 32'd1);
    idle();
    tick();

    // backpressure hold then flush
    inst = 32'h002081B3; rf_rdata1 = 32'hA; in_valid = 1'b1;
    tick();
    out_ready = 1'b0; inst = 32'h123453B7; rf_rdata1 = 32'h5;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_rd_hold", 32'(rd_out), 32'd3);
      chk("bp_rr1_hold", rr1, 32'hA);
    end
    flush = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    idle();
    tick();
    chk("flush_not_accepted", 32'(out_valid), 32'd0);

    // M extension gating and unknown opcode
    inst = 32'h0220C1B3; in_valid = 1'b1;
    tick();
    chk("div_m0_illegal", 32'(dcr0[23]), 32'd1);
    chk("div_m0_rd", 32'(rd_out0), 32'd0);
    chk("div_m1_legal", 32'(dcr[23]), 32'd0);
    chk("div_m1_rd", 32'(rd_out), 32'd3);
    chk("div_m1_mdu_op", 32'(dcr[10:7]), 32'b1100);
    inst = 32'h022081B3;
    tick();
    chk("mul_m0_legal", 32'(dcr0[23]), 32'd0);
    chk("mul_m0_rd", 32'(rd_out0), 32'd3);
    inst = 32'h0000007F;
    tick();
    chk("unknown_illegal", 32'(dcr[23]), 32'd1);
    chk("unknown_rd", 32'(rd_out), 32'd0);
    chk("unknown_passes", 32'(out_valid), 32'd1);
    idle();
    tick();

    // randomized traffic with a transaction-level output model
    m_ov = 1'b0; m_out = '0; m_pc = '0;
    for (int it = 0; it < 400; it++) begin
      w = $urandom();
      inst = {w[31:7], opcs[$urandom_range(0, 9)]};
      if (inst[6:0] == 7'h33) inst[31:25] = (w[1:0] == 2'd0) ? 7'h01 : (w[1:0] == 2'd1 ? 7'h20 : 7'h00);
      inst[19:15] = 5'($urandom_range(0, 3));
      inst[24:20] = 5'($urandom_range(0, 3));
      pc_in = $urandom(); rf_rdata1 = $urandom(); rf_rdata2 = $urandom();
      for (int i = 0; i < FD; i++) begin
        fv[i] = ($urandom_range(0, 1) == 1);
        frd[i] = 5'($urandom_range(0, 3));
        fav[i] = ($urandom_range(0, 3) != 0);
        fdat[i] = $urandom();
      end
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      #1 e = model(1'b1);
      exp_ir = !flush && !e.stall && (!m_ov || out_ready);
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
      if (flush) m_ov = 1'b0;
      else if (exp_ir && in_valid) begin m_ov = 1'b1; m_out = e; m_pc = pc_in; end
      else if (out_ready) m_ov = 1'b0;
      tick();
      chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("rnd_rr1", rr1, m_out.rr1);
        chk("rnd_rr2", rr2, m_out.rr2);
        chk("rnd_imm", imm_out, m_out.imm);
        chk("rnd_target", target_pc, m_out.tgt);
        chk("rnd_rd", 32'(rd_out), 32'(m_out.rd));
        chk("rnd_dcr", 32'(dcr), 32'(m_out.dcr));
        chk("rnd_pc_out", pc_out, m_pc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
